sys_alarm: RTL and testbench
============================

SYS_ALARM -- requirements
Module: sys_alarm

Interface
REQ-001 Parameter: MCW, 8, width of the match counter output.
REQ-002 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-003 Rst  input  1  asynchronous, active-high reset; one clock domain only.
REQ-004 count  input  32  free-running timestamp from the system counter, same clock domain.
REQ-005 Arm  input  1  single-cycle strobe; loads Cmp_val/Period/Mode and arms the alarm.
REQ-006 Disarm  input  1  single-cycle strobe; returns the block to IDLE.
REQ-007 Cmp_val  input  32  absolute target timestamp, sampled on Arm.
REQ-008 Period  input  32  reload interval for periodic mode, sampled on Arm.
REQ-009 Mode  input  1  0 = one-shot, 1 = periodic; sampled on Arm.
REQ-010 Irq_ack  input  1  single-cycle strobe clearing Irq and Missed.
REQ-011 Irq  output  1  registered alarm flag, level-held until acknowledged.
REQ-012 Armed  output  1  high while in ARMED state.
REQ-013 Missed  output  1  sticky flag: a match occurred while Irq was already pending.
REQ-014 Match_cnt  output  MCW  number of matches since last Arm, saturating.

Function
REQ-015 States SHALL be IDLE, ARMED, FIRED (FIRED = one-shot match taken, waiting for ack).
REQ-016 Match condition SHALL be bit 31 of (count - target) == 0, i.e. wrap-safe signed compare; targets up to 2^31-1 ticks ahead are valid.
REQ-017 IDLE -> ARMED on Arm; target <= Cmp_val, Match_cnt <= 0, Missed <= 0, Irq <= 0.
REQ-018 In ARMED, a match SHALL set Irq in the next cycle (one-cycle latency from the count value satisfying REQ-016).
REQ-019 One-shot: ARMED -> FIRED on match; FIRED -> IDLE on Irq_ack.
REQ-020 Periodic: stay ARMED on match; target <= target + Period (mod 2^32).
REQ-021 Periodic with Period == 0 SHALL behave as one-shot.
REQ-022 A match while Irq == 1 and no Irq_ack in the same cycle SHALL set Missed.
REQ-023 Match_cnt SHALL increment on every match and saturate at all-ones.
REQ-024 Irq_ack with a match in the same cycle: match wins; Irq stays 1, Missed not set.
REQ-025 Arm while ARMED/FIRED SHALL re-arm per REQ-017 (restart).
REQ-026 Disarm from any state -> IDLE, Irq <= 0; Missed and Match_cnt hold. Arm and Disarm together: Disarm wins.
REQ-027 Cmp_val already in the past at Arm SHALL match on the first ARMED cycle.
REQ-028 Irq_ack in IDLE or with Irq == 0 SHALL have no effect other than clearing Missed.

Reset
REQ-029 Rst SHALL asynchronously force state IDLE, target 0, Irq 0, Armed 0, Missed 0, Match_cnt 0.
REQ-030 Rst mid-operation SHALL abandon any pending alarm; no Irq after release until a new Arm.

Verification
REQ-031 One-shot: count from 100, Arm Cmp_val=110, Mode=0 -> Irq rises the cycle after count==110; Armed falls; Match_cnt=1.
REQ-032 Periodic: Cmp_val=50, Period=20, ack each Irq -> Irq at counts 50, 70, 90; Missed stays 0.
REQ-033 Wrap: count=32'hFFFF_FFF0, Cmp_val=32'h0000_0005 -> no Irq until count wraps to 5; Irq the next cycle.
REQ-034 Missed: Period=4, never ack -> Missed set at second match; Match_cnt counts up and saturates at 255.
REQ-035 Past target: count=1000, Arm Cmp_val=900 -> Irq on second cycle after Arm.
REQ-036 Reset: assert Rst between clock edges while Irq=1 -> all outputs 0 immediately, no edge required.

Source files
------------

// File: rtl/sys_alarm.sv
// sys_alarm: timestamp compare alarm with one-shot/periodic modes, sticky miss flag and match counter
module sys_alarm #(
   parameter int MCW = 8
) (
   input  logic           Clk,
   input  logic           Rst,
   input  logic [31:0]    count,
   input  logic           Arm,
   input  logic           Disarm,
   input  logic [31:0]    Cmp_val,
   input  logic [31:0]    Period,
   input  logic           Mode,
   input  logic           Irq_ack,
   output logic           Irq,
   output logic           Armed,
   output logic           Missed,
   output logic [MCW-1:0] Match_cnt
);
   typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;
   state_t state, state_nxt;
   logic [31:0] target, per_r, diff;
   logic mode_r, match, reload;
   assign diff = count - target;
   assign match = state == ARMED && !diff[31];
   assign reload = mode_r && per_r != 32'd0;
   // state register
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) state <= IDLE;
      else state <= state_nxt;
   // next state: Disarm beats Arm, Arm beats match/ack; a zero period acts as one-shot
   always_comb begin
      state_nxt = Disarm ? IDLE :
                  Arm ? ARMED :
                  (match && !reload) ? FIRED :
                  (state == FIRED && Irq_ack) ? IDLE : state;
   end
   // state-derived outputs
   always_comb begin
      Armed = state == ARMED;
   end
   // target reload, interrupt, miss flag and saturating match counter; a match wins over a same-cycle ack
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
         target    <= 32'd0;
         per_r     <= 32'd0;
         mode_r    <= 1'b0;
         Irq       <= 1'b0;
         Missed    <= 1'b0;
         Match_cnt <= '0;
      end else if (Disarm) begin
         Irq <= 1'b0;
      end else if (Arm) begin
         target    <= Cmp_val;
         per_r     <= Period;
         mode_r    <= Mode;
         Irq       <= 1'b0;
         Missed    <= 1'b0;
         Match_cnt <= '0;
      end else if (match) begin
         Irq    <= 1'b1;
         Missed <= !Irq_ack && (Missed || Irq);
         if (!(&Match_cnt)) Match_cnt <= Match_cnt + MCW'(1);
         if (reload) target <= target + per_r;
      end else if (Irq_ack) begin
         Irq    <= 1'b0;
         Missed <= 1'b0;
      end
endmodule

// File: tb/tb_sys_alarm.sv
// tb_sys_alarm: directed scenarios plus random traffic checked against a behavioural alarm model
module tb_sys_alarm;
   logic        Clk, Rst, Arm, Disarm, Mode, Irq_ack;
   logic [31:0] count, Cmp_val, Period;
   logic        Irq, Armed, Missed;
   logic [7:0]  Match_cnt;
   int checks, failures;

   bit          m_on, m_irq, m_missed, m_mode;
   logic [31:0] m_tgt, m_per;
   int          m_cnt;

   sys_alarm #(.MCW(8)) dut (
      .Clk(Clk), .Rst(Rst), .count(count), .Arm(Arm), .Disarm(Disarm),
      .Cmp_val(Cmp_val), .Period(Period), .Mode(Mode), .Irq_ack(Irq_ack),
      .Irq(Irq), .Armed(Armed), .Missed(Missed), .Match_cnt(Match_cnt)
   );

   initial begin
      Clk = 0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t count=%0d)", tag, got, exp, $time, count);
      end
   endtask

   task automatic model_reset();
      m_on = 0; m_irq = 0; m_missed = 0; m_mode = 0; m_tgt = 0; m_per = 0; m_cnt = 0;
   endtask

   // one clock of the alarm rules, using the inputs present at the edge
   task automatic model_step();
      int  d;
      bit  hit;
      d = int'(count - m_tgt);
      hit = m_on && d >= 0;
      if (Disarm) begin
         m_on = 0; m_irq = 0;
      end else if (Arm) begin
         m_on = 1; m_irq = 0; m_missed = 0; m_cnt = 0;
         m_tgt = Cmp_val; m_per = Period; m_mode = Mode;
      end else if (hit) begin
         if (Irq_ack) m_missed = 0;
         else if (m_irq) m_missed = 1;
         m_irq = 1;
         m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
         if (m_mode && m_per != 0) m_tgt = m_tgt + m_per;
         else m_on = 0;
      end else if (Irq_ack) begin
         m_irq = 0; m_missed = 0;
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      model_step();
      #1;
      chk("irq", Irq, m_irq);
      chk("armed", Armed, m_on);
      chk("missed", Missed, m_missed);
      chk("match_cnt", Match_cnt, m_cnt);
      Arm = 0; Disarm = 0; Irq_ack = 0;
      count = count + 1;
   endtask

   initial begin
      checks = 0; failures = 0;
      Rst = 1; Arm = 0; Disarm = 0; Mode = 0; Irq_ack = 0;
      count = 100; Cmp_val = 0; Period = 0;
      model_reset();
      #12;
      chk("rst_irq", Irq, 0);
      chk("rst_armed", Armed, 0);
      chk("rst_missed", Missed, 0);
      chk("rst_cnt", Match_cnt, 0);
      Rst = 0;
      Arm = 1; Cmp_val = 110; Mode = 0; Period = 7;
      tick();
      repeat (9) tick();
      chk("os_early", Irq, 0);
      tick();
      chk("os_irq", Irq, 1);
      chk("os_armed", Armed, 0);
      chk("os_cnt", Match_cnt, 1);
      Irq_ack = 1;
      tick();
      chk("os_ack", Irq, 0);
      count = 40; Arm = 1; Cmp_val = 50; Period = 20; Mode = 1;
      tick();
      repeat (60) begin
         Irq_ack = Irq;
         tick();
      end
      chk("per_cnt", Match_cnt, 3);
      chk("per_missed", Missed, 0);
      chk("per_armed", Armed, 1);
      count = 32'hFFFF_FFF0; Arm = 1; Cmp_val = 5; Mode = 0;
      tick();
      repeat (20) tick();
      chk("wrap_early", Irq, 0);
      tick();
      chk("wrap_irq", Irq, 1);
      Arm = 1; Cmp_val = count + 2; Period = 4; Mode = 1;
      tick();
      repeat (1100) tick();
      chk("miss_cnt", Match_cnt, 255);
      chk("miss_flag", Missed, 1);
      Irq_ack = 1;
      tick();
      count = 1000; Arm = 1; Cmp_val = 900; Mode = 0;
      tick();
      chk("past_first", Irq, 0);
      tick();
      chk("past_irq", Irq, 1);
      #2 Rst = 1;
      #1;
      chk("arst_irq", Irq, 0);
      chk("arst_armed", Armed, 0);
      chk("arst_missed", Missed, 0);
      chk("arst_cnt", Match_cnt, 0);
      model_reset();
      #1 Rst = 0;
      repeat (20) tick();
      chk("arst_quiet", Irq, 0);
      Arm = 1; Disarm = 1; Cmp_val = count; Mode = 0;
      tick();
      chk("both_armed", Armed, 0);
      repeat (2000) begin
         Arm = $urandom_range(0, 39) == 0;
         Disarm = $urandom_range(0, 99) == 0;
         Irq_ack = $urandom_range(0, 7) == 0;
         Cmp_val = count + $urandom_range(0, 60) - 15;
         Period = $urandom_range(0, 12);
         Mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 199) == 0) count = count + $urandom_range(0, 1000);
         if ($urandom_range(0, 499) == 0) count = $urandom();
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
